// File: rtl/tile_buffer.sv
// 32x32 RGB565 tile RAM with fragment write, clear-fill and flush hand-off to tile_writer.
// Write port is shared by fragments (idle only) and the clear counter; read port belongs to tile_writer.
module tile_buffer (
    input  logic        gpu_clk,
    input  logic        gpu_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_color,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_stride,
    input  logic        frag_valid,
    output logic        frag_ready,
    input  logic [4:0]  frag_x,
    input  logic [4:0]  frag_y,
    input  logic [15:0] frag_color,
    output logic        writer_start,
    output logic [31:0] writer_addr,
    output logic [15:0] writer_stride,
    input  logic        writer_reading,
    input  logic [9:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] OP_CLEAR       = 2'd0;
    localparam logic [1:0] OP_FLUSH       = 2'd1;
    localparam logic [1:0] OP_FLUSH_CLEAR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FLUSH_START,
        S_FLUSH_ARM,
        S_FLUSH_WAIT
    } state_t;

    state_t      r_state;
    logic [9:0]  r_clr_cnt;
    logic [15:0] r_color;
    logic        r_clear_after;
    logic        r_writer_start;
    logic [31:0] r_writer_addr;
    logic [15:0] r_writer_stride;
    logic        r_done;
    logic [15:0] r_rd_data;
    logic [15:0] r_mem [1024];

    logic        w_idle;
    logic        w_clearing;
    logic        w_cmd_fire;
    logic        w_frag_fire;
    logic        w_we;
    logic [9:0]  w_waddr;
    logic [15:0] w_wdata;

    assign w_idle      = (r_state == S_IDLE);
    assign w_clearing  = (r_state == S_CLEAR);
    assign cmd_ready   = w_idle && !writer_reading;
    // A pending command blocks fragments even when it cannot be accepted yet.
    assign frag_ready  = w_idle && !cmd_valid;
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_frag_fire = frag_valid && frag_ready;

    assign w_we    = w_frag_fire || w_clearing;
    assign w_waddr = w_clearing ? r_clr_cnt : {frag_y, frag_x};
    assign w_wdata = w_clearing ? r_color   : frag_color;

    always_ff @(posedge gpu_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data <= r_mem[rd_addr];
    end

    always_ff @(posedge gpu_clk) begin
        if (gpu_rst) begin
            r_state         <= S_IDLE;
            r_clr_cnt       <= 10'd0;
            r_color         <= 16'd0;
            r_clear_after   <= 1'b0;
            r_writer_start  <= 1'b0;
            r_writer_addr   <= 32'd0;
            r_writer_stride <= 16'd0;
            r_done          <= 1'b0;
        end else begin
            r_writer_start <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        case (cmd_op)
                            OP_CLEAR: begin
                                r_color   <= cmd_color;
                                r_clr_cnt <= 10'd0;
                                r_state   <= S_CLEAR;
                            end
                            OP_FLUSH, OP_FLUSH_CLEAR: begin
                                r_writer_addr   <= cmd_addr;
                                r_writer_stride <= cmd_stride;
                                r_color         <= cmd_color;
                                r_clear_after   <= (cmd_op == OP_FLUSH_CLEAR);
                                r_writer_start  <= 1'b1;
                                r_state         <= S_FLUSH_START;
                            end
                            default: r_done <= 1'b1;
                        endcase
                    end
                end
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 10'd1;
                    if (r_clr_cnt == 10'd1023) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_FLUSH_START: r_state <= S_FLUSH_ARM;
                // tile_writer raises reading one cycle after it samples start.
                S_FLUSH_ARM:   r_state <= S_FLUSH_WAIT;
                S_FLUSH_WAIT: begin
                    if (!writer_reading) begin
                        if (r_clear_after) begin
                            r_clr_cnt <= 10'd0;
                            r_state   <= S_CLEAR;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign writer_start  = r_writer_start;
    assign writer_addr   = r_writer_addr;
    assign writer_stride = r_writer_stride;
    assign rd_data       = r_rd_data;
    assign busy          = !w_idle;
    assign done          = r_done;

endmodule

// File: tb/tb_tile_buffer.sv
// Scoreboarded bench for tile_buffer: directed command/timing scenarios plus randomized
// fragment/readback traffic against a flat-array tile model.
module tb_tile_buffer;

    logic        gpu_clk = 1'b0;
    logic        gpu_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd3;
    logic [15:0] cmd_color = 16'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [15:0] cmd_stride = 16'd0;
    logic        frag_valid = 1'b0;
    logic        frag_ready;
    logic [4:0]  frag_x = 5'd0;
    logic [4:0]  frag_y = 5'd0;
    logic [15:0] frag_color = 16'd0;
    logic        writer_start;
    logic [31:0] writer_addr;
    logic [15:0] writer_stride;
    logic        writer_reading;
    logic [9:0]  rd_addr = 10'd0;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;

    tile_buffer dut (
        .gpu_clk(gpu_clk), .gpu_rst(gpu_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_color(cmd_color), .cmd_addr(cmd_addr), .cmd_stride(cmd_stride),
        .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_x(frag_x),
        .frag_y(frag_y), .frag_color(frag_color),
        .writer_start(writer_start), .writer_addr(writer_addr),
        .writer_stride(writer_stride), .writer_reading(writer_reading),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 gpu_clk = ~gpu_clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Tile model: pixel (x,y) lives at index y*32+x.
    logic [15:0] model_mem [1024];

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] exp;
    } rd_exp_t;
    rd_exp_t sb_q[$];
    rd_exp_t mon_e;
    logic    rd_req = 1'b0;
    logic    rd_vld_q = 1'b0;

    // Writer model: raises reading the cycle after it samples start, holds for wr_hold cycles.
    int   wr_hold = 100;
    int   wr_left = 0;
    logic force_reading = 1'b0;
    assign writer_reading = (wr_left != 0) || force_reading;

    always @(posedge gpu_clk) begin
        rd_vld_q <= rd_req;
        if (writer_start) wr_left <= wr_hold;
        else if (wr_left != 0) wr_left <= wr_left - 1;
    end

    always @(negedge gpu_clk) begin
        if (rd_vld_q) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h expected none", rd_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk($sformatf("rd[%0d]", mon_e.addr), {16'd0, rd_data}, {16'd0, mon_e.exp});
            end
        end
    end

    task automatic model_fill(input logic [15:0] c);
        for (int i = 0; i < 1024; i++) model_mem[i] = c;
    endtask

    task automatic read_range(input int lo, input int hi);
        rd_exp_t e;
        for (int a = lo; a <= hi; a++) begin
            rd_addr = a[9:0];
            rd_req  = 1'b1;
            e.addr  = a[9:0];
            e.exp   = model_mem[a];
            sb_q.push_back(e);
            @(posedge gpu_clk); #1;
        end
        rd_req = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] col,
                            input logic [31:0] addr, input logic [15:0] str, output int waited);
        cmd_op = op; cmd_color = col; cmd_addr = addr; cmd_stride = str;
        cmd_valid = 1'b1;
        waited = 0;
        @(negedge gpu_clk);
        while (!cmd_ready && waited < 5000) begin
            waited++;
            @(negedge gpu_clk);
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_timeout: got ready 0 expected 1");
        end
        @(posedge gpu_clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Leaves frag_valid asserted so callers can issue back-to-back fragments.
    task automatic send_frag(input logic [4:0] x, input logic [4:0] y, input logic [15:0] c,
                             output int waited);
        frag_x = x; frag_y = y; frag_color = c;
        frag_valid = 1'b1;
        waited = 0;
        @(negedge gpu_clk);
        while (!frag_ready && waited < 5000) begin
            waited++;
            @(negedge gpu_clk);
        end
        if (!frag_ready) begin
            n_cmp++; n_err++;
            $display("FAIL frag_timeout: got ready 0 expected 1");
        end else begin
            @(posedge gpu_clk);
            model_mem[int'(y) * 32 + int'(x)] = c;
            #1;
        end
    endtask

    // Observe from the cycle after acceptance until done; n = cycles after acceptance.
    task automatic watch(input int max, output int n, output int st_first, output int st_cnt,
                         output bit idle_seen, output bit addr_moved);
        logic [31:0] a0;
        logic [15:0] s0;
        a0 = writer_addr;
        s0 = writer_stride;
        n = 0; st_first = 0; st_cnt = 0; idle_seen = 0; addr_moved = 0;
        do begin
            @(negedge gpu_clk);
            n++;
            if (writer_start) begin
                st_cnt++;
                if (st_first == 0) st_first = n;
            end
            if (!done && (frag_ready || cmd_ready || !busy)) idle_seen = 1;
            if (writer_addr !== a0 || writer_stride !== s0) addr_moved = 1;
        end while (!done && n < max);
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no done expected done within %0d", max);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int  w, w2, n, sf, sc;
        bit  idl, mv, seen;
        logic [4:0] rx, ry;
        logic [15:0] rc;

        repeat (3) @(posedge gpu_clk);
        #1 gpu_rst = 1'b0;
        @(negedge gpu_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_writer_start", writer_start, 0);
        chk("rst_writer_addr", writer_addr, 0);
        chk("rst_writer_stride", writer_stride, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_frag_ready", frag_ready, 1);
        @(posedge gpu_clk); #1;

        // Clear to red: done lands 1025 cycles after acceptance.
        send_cmd(2'd0, 16'hF800, 32'd0, 16'd0, w);
        watch(2000, n, sf, sc, idl, mv);
        chk("clr_done_cycle", n, 1025);
        chk("clr_ready_low", idl, 0);
        chk("clr_ready_at_done", cmd_ready, 1);
        chk("clr_no_start", sc, 0);
        model_fill(16'hF800);
        @(posedge gpu_clk); #1;
        chk("clr_done_pulse", done, 0);
        read_range(0, 1023);

        // Back-to-back fragments.
        send_frag(5'd3, 5'd2, 16'h07E0, w);
        send_frag(5'd31, 5'd31, 16'h1234, w2);
        frag_valid = 1'b0;
        chk("frag_b2b", w + w2, 0);
        read_range(66, 67);
        read_range(1023, 1023);

        // Flush: start at +1, reading from +2 for wr_hold cycles, falls at u=+2+hold, done u+1.
        wr_hold = 100;
        send_cmd(2'd1, 16'd0, 32'h1000_0000, 16'd2048, w);
        watch(1000, n, sf, sc, idl, mv);
        chk("flush_start_cycle", sf, 1);
        chk("flush_start_width", sc, 1);
        chk("flush_done_cycle", n, 2 + wr_hold + 1);
        chk("flush_ready_low", idl, 0);
        chk("flush_addr_stable", mv, 0);
        chk("flush_addr", writer_addr, 32'h1000_0000);
        chk("flush_stride", writer_stride, 2048);
        @(posedge gpu_clk); #1;

        // Flush-then-clear: clear runs u+1..u+1024, done u+1025.
        send_cmd(2'd2, 16'h001F, 32'h2000_0040, 16'd4096, w);
        watch(3000, n, sf, sc, idl, mv);
        chk("fc_start_cycle", sf, 1);
        chk("fc_done_cycle", n, 2 + wr_hold + 1025);
        chk("fc_ready_low", idl, 0);
        chk("fc_addr", writer_addr, 32'h2000_0040);
        chk("fc_stride", writer_stride, 4096);
        model_fill(16'h001F);
        @(posedge gpu_clk); #1;
        read_range(0, 1023);

        // Command and fragment in the same cycle: command wins, fragment lands after done.
        cmd_op = 2'd0; cmd_color = 16'h0000; cmd_valid = 1'b1;
        frag_x = 5'd5; frag_y = 5'd5; frag_color = 16'hFFFF; frag_valid = 1'b1;
        @(negedge gpu_clk);
        chk("same_cyc_frag_stall", frag_ready, 0);
        chk("same_cyc_cmd_ready", cmd_ready, 1);
        @(posedge gpu_clk); #1;
        cmd_valid = 1'b0;
        watch(2000, n, sf, sc, idl, mv);
        chk("same_cyc_done_cycle", n, 1025);
        chk("same_cyc_frag_ready", frag_ready, 1);
        @(posedge gpu_clk);
        model_fill(16'h0000);
        model_mem[5 * 32 + 5] = 16'hFFFF;
        #1 frag_valid = 1'b0;
        read_range(164, 166);

        // Randomized fragments, readbacks and no-ops.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 4))
                0, 1: begin
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                        rx = 5'($urandom_range(0, 31));
                        ry = 5'($urandom_range(0, 31));
                        rc = 16'($urandom);
                        send_frag(rx, ry, rc, w);
                    end
                    frag_valid = 1'b0;
                end
                2: read_range(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
                3: begin
                    w = int'($urandom_range(0, 1016));
                    read_range(w, w + 7);
                end
                default: begin
                    send_cmd(2'd3, 16'd0, 32'd0, 16'd0, w);
                    watch(10, n, sf, sc, idl, mv);
                    chk("noop_done_cycle", n, 1);
                    @(posedge gpu_clk); #1;
                end
            endcase
        end

        // Reset while clear counter is at 500.
        send_cmd(2'd0, 16'hABCD, 32'd0, 16'd0, w);
        repeat (500) @(posedge gpu_clk);
        #1 gpu_rst = 1'b1;
        @(posedge gpu_clk); #1;
        gpu_rst = 1'b0;
        @(negedge gpu_clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", writer_addr, 0);
        seen = 0;
        repeat (1100) begin
            @(negedge gpu_clk);
            if (done) seen = 1;
        end
        chk("rst_mid_no_done", seen, 0);
        @(posedge gpu_clk); #1;

        // Flush stalls while the writer still reads.
        force_reading = 1'b1;
        cmd_op = 2'd1; cmd_addr = 32'h3000_0000; cmd_stride = 16'd512; cmd_valid = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge gpu_clk);
            if (cmd_ready) seen = 1;
        end
        chk("stall_ready_low", seen, 0);
        @(posedge gpu_clk); #1;
        force_reading = 1'b0;
        @(negedge gpu_clk);
        chk("stall_ready_high", cmd_ready, 1);
        @(posedge gpu_clk); #1;
        cmd_valid = 1'b0;
        watch(1000, n, sf, sc, idl, mv);
        chk("stall_flush_done", n, 2 + wr_hold + 1);
        chk("stall_flush_addr", writer_addr, 32'h3000_0000);

        repeat (3) @(posedge gpu_clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
